// File: rtl/if_stage_pkg.sv
// Shared types, widths and FSM encodings for the RV32I instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned STALL_IF    = 1;

  typedef logic [STALL_W-1:0]     stall_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t ZERO_WORD = '0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_B0   = 3'd1;
  localparam logic [2:0] ST_B1   = 3'd2;
  localparam logic [2:0] ST_B2   = 3'd3;
  localparam logic [2:0] ST_B3   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Byte lane being fetched in B0..B3; meaningless in other states.
  function automatic logic [1:0] byte_idx(input logic [2:0] st);
    return 2'(st - ST_B0);
  endfunction

  function automatic logic is_fetch(input logic [2:0] st);
    return (st >= ST_B0) && (st <= ST_B3);
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with +4 incrementer, pending-redirect flag and target latch.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  input  logic       take_i,
  input  logic       inc_i,
  output logic       redirect_c_o,
  output inst_addr_t pc_o
);

  logic       pend_q, pend_d;
  inst_addr_t tgt_q, tgt_d;
  inst_addr_t pc_q, pc_d;

  // A live branch this cycle overrides any older latched target.
  assign redirect_c_o = branch_flag_i | pend_q;
  assign pc_o         = pc_q;

  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    pc_d   = pc_q;
    if (branch_flag_i) begin
      pend_d = 1'b1;
      tgt_d  = branch_target_i;
    end
    if (take_i) begin
      pend_d = 1'b0;
      pc_d   = branch_flag_i ? branch_target_i : tgt_q;
    end else if (inc_i) begin
      pc_d = pc_q + INST_ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
      pc_q   <= RESET_PC;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      pc_q   <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads and
// holds it in DONE until IF/ID takes it or a redirect arrives.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  stall_bus_t stall,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output logic       mem_req_o,
  output inst_addr_t mem_addr_o,
  input  logic       mem_ack_i,
  input  logic [7:0] mem_data_i,
  output inst_addr_t pc_o,
  output inst_t      inst_o,
  output logic       stallreq_o
);

  logic [2:0] state_q, state_d;
  inst_t      inst_q, inst_d;
  logic       fetch;
  logic       redirect_c;
  logic       take;
  logic       inc;
  inst_addr_t pc;

  // stall[0] is implied by holding the PC outside DONE; upper bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:2], stall[0]};

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .take_i         (take),
    .inc_i          (inc),
    .redirect_c_o   (redirect_c),
    .pc_o           (pc)
  );

  assign fetch      = is_fetch(state_q);
  assign mem_req_o  = fetch;
  assign mem_addr_o = fetch ? (pc + INST_ADDR_W'(byte_idx(state_q))) : pc;
  assign stallreq_o = (state_q != ST_DONE);
  assign pc_o       = pc;
  assign inst_o     = inst_q;

  // Next state; an outstanding request always completes before a redirect is taken.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    take    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take    = redirect_c;
        state_d = ST_B0;
      end
      ST_B0, ST_B1, ST_B2, ST_B3: begin
        if (mem_ack_i) begin
          if (redirect_c) begin
            take    = 1'b1;
            state_d = ST_B0;
          end else begin
            inst_d[{byte_idx(state_q), 3'b000} +: 8] = mem_data_i;
            state_d = (state_q == ST_B3) ? ST_DONE : (state_q + 3'd1);
          end
        end
      end
      ST_DONE: begin
        if (redirect_c) begin
          take    = 1'b1;
          state_d = ST_B0;
        end else if (!stall[STALL_IF]) begin
          inc     = 1'b1;
          state_d = ST_B0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      inst_q  <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: byte memory model with per-cycle ack control and a
// scoreboard of expected {pc, inst} pairs popped on every entry into DONE.
module tb_if_stage;
  import if_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  stall_bus_t  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stallreq;

  logic        ack_en;
  logic        busy_prev = 1'b1;
  int          chk_n = 0;
  int          err_n = 0;
  int          cyc = 0;
  int          t0 = 0;
  exp_t        sb_q[$];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_flag_i  (branch_flag),
    .branch_target_i(branch_target),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_ack_i      (mem_ack),
    .mem_data_i     (mem_data),
    .pc_o           (pc),
    .inst_o         (inst),
    .stallreq_o     (stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h03;
      32'd1:   return 8'h00;
      32'd2:   return 8'h00;
      32'd3:   return 8'h13;
      default: return a[7:0] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  assign mem_ack  = mem_req && ack_en;
  assign mem_data = mem_byte(mem_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = mem_word(p);
    sb_q.push_back(e);
  endtask

  // Advance one cycle, sample after the edge, and score any fresh DONE entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!stallreq && busy_prev) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_inst", inst, e.inst);
      end
    end
    busy_prev = stallreq;
  endtask

  initial begin
    rst           = 1'b0;
    stall         = '0;
    branch_flag   = 1'b0;
    branch_target = '0;
    ack_en        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stallreq", 32'(stallreq), 32'd1);

    // Zero-wait fetch of 0x13000003 at address 0
    push(32'h0);
    rst = 1'b1;
    tick();
    t0 = cyc;
    check("zw_addr0", mem_addr, 32'h0);
    check("zw_req", 32'(mem_req), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("zw_addr", mem_addr, 32'(i));
    end
    tick();
    check("zw_lat", 32'(cyc - t0), 32'd4);
    check("zw_done_req", 32'(mem_req), 32'd0);
    check("zw_done_stallreq", 32'(stallreq), 32'd0);
    check("zw_inst", inst, 32'h1300_0003);

    // Two wait cycles on byte 1 of the fetch at 4
    push(32'h4);
    tick();
    t0 = cyc;
    check("ws_addr4", mem_addr, 32'h4);
    tick();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_addr_hold", mem_addr, 32'h5);
      check("ws_stallreq", 32'(stallreq), 32'd1);
      if (i == 2) ack_en = 1'b1;
      if (i < 2) tick();
    end
    tick();
    check("ws_addr6", mem_addr, 32'h6);
    tick();
    tick();
    check("ws_lat", 32'(cyc - t0), 32'd6);

    // Downstream stall holds DONE
    stall = 6'b000011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc", pc, 32'h4);
      check("st_inst", inst, mem_word(32'h4));
      check("st_req", 32'(mem_req), 32'd0);
    end
    stall = '0;
    tick();
    check("st_rel_addr", mem_addr, 32'h8);
    check("st_rel_req", 32'(mem_req), 32'd1);

    // Redirect during B2 with the ack withheld two cycles; fetch at 8 is abandoned
    tick();
    tick();
    check("br_b2_addr", mem_addr, 32'hA);
    ack_en        = 1'b0;
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_flag   = 1'b0;
    check("br_hold1", mem_addr, 32'hA);
    check("br_hold_req", 32'(mem_req), 32'd1);
    tick();
    check("br_hold2", mem_addr, 32'hA);
    ack_en = 1'b1;
    tick();
    check("br_tgt_addr", mem_addr, 32'h100);
    check("br_tgt_pc", pc, 32'h100);
    push(32'h100);
    repeat (4) tick();
    check("br_done", 32'(stallreq), 32'd0);

    // Redirect in DONE beats stall[1]
    stall         = 6'b000010;
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_flag = 1'b0;
    stall       = '0;
    check("rd_addr", mem_addr, 32'hFFFF_FFFC);
    check("rd_req", 32'(mem_req), 32'd1);
    push(32'hFFFF_FFFC);
    repeat (4) tick();

    // PC wraps to 0 after 0xFFFFFFFC
    push(32'h0);
    tick();
    check("wrap_addr", mem_addr, 32'h0);
    tick();
    check("wrap_b1_addr", mem_addr, 32'h1);

    // Reset mid-B1 aborts the fetch at once
    rst = 1'b0;
    #1;
    check("mr_pc", pc, 32'h0);
    check("mr_inst", inst, 32'h0);
    check("mr_req", 32'(mem_req), 32'd0);
    check("mr_stallreq", 32'(stallreq), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("mr_restart", mem_addr, 32'h0);
    repeat (4) tick();
    check("mr_done", 32'(stallreq), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end

endmodule
